// File: rtl/mdio_pkg.sv
// mdio_pkg: shared MDIO frame constants, FSM encoding and field positions
package mdio_pkg;
  typedef enum logic [2:0] {S_PRE, S_ST, S_OP, S_ADDR, S_TA, S_DATA} state_t;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;
  localparam int PHY_MSB  = 27;
  localparam int REG_MSB  = 22;
  localparam int DATA_MSB = 15;
endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: synchronizes MDC and the resolved MDIO line, strobing once per MDC rise
module mdio_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  input  logic line,
  output logic sample_stb,
  output logic sample_bit
);
  logic [2:0] mdc_s;
  logic [1:0] line_s;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mdc_s  <= '0;
      line_s <= '0;
    end else begin
      mdc_s  <= {mdc_s[1:0], mdc};
      line_s <= {line_s[0], line};
    end
  // line_s[1] is aligned with mdc_s[1], so the bit is taken at the synchronized rise
  assign sample_stb = mdc_s[1] & ~mdc_s[2];
  assign sample_bit = line_s[1];
endmodule

// File: rtl/mdio_frame_decoder.sv
// mdio_frame_decoder: passive MDIO listener rebuilding management frames and flagging protocol errors
module mdio_frame_decoder
  import mdio_pkg::*;
#(
  parameter int PREAMBLE_MIN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  input  logic        mdio_in,
  output logic [31:0] frame,
  output logic [4:0]  phy_addr,
  output logic [4:0]  reg_addr,
  output logic [15:0] data,
  output logic        is_read,
  output logic        frame_valid,
  output logic        err_op,
  output logic        err_ta,
  output logic        busy,
  output logic [7:0]  frame_count
);
  localparam int PW = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PW-1:0] PMAX = PW'(PREAMBLE_MIN);
  state_t state, state_n;
  logic stb, b, rd, rd_n, done, bad_op, bad_ta;
  logic [PW-1:0] pre, pre_n;
  logic [4:0] idx;
  logic [30:0] sh;
  logic [31:0] word;
  logic [1:0] pair;
  mdio_sync_edge u_sync (
    .clk       (clk),
    .reset     (reset),
    .mdc       (mdc),
    .line      (mdio_oe ? mdio_out : mdio_in),
    .sample_stb(stb),
    .sample_bit(b)
  );
  assign word = {sh, b};
  assign pair = word[1:0];
  assign busy = state != S_PRE;
  // idx counts frame bits already captured; the ST-entry zero is bit 0
  always_comb begin
    state_n = state;
    pre_n   = pre;
    rd_n    = rd;
    done    = 1'b0;
    bad_op  = 1'b0;
    bad_ta  = 1'b0;
    if (stb) begin
      pre_n = '0;
      case (state)
        S_PRE:
          if (b) pre_n = (pre == PMAX) ? pre : pre + PW'(1);
          else if (pre == PMAX) state_n = S_ST;
        S_ST: state_n = (pair == ST) ? S_OP : S_PRE;
        S_OP:
          if (idx == 5'd3) begin
            bad_op  = pair != OP_WRITE && pair != OP_READ;
            rd_n    = pair == OP_READ;
            state_n = bad_op ? S_PRE : S_ADDR;
          end
        S_ADDR: if (idx == 5'd13) state_n = S_TA;
        S_TA:
          if (idx == 5'd15) begin
            bad_ta  = rd ? b : pair != TA_WRITE;
            state_n = bad_ta ? S_PRE : S_DATA;
          end
        default:
          if (idx == 5'd31) begin
            done    = 1'b1;
            state_n = S_PRE;
          end
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= S_PRE;
      pre         <= '0;
      rd          <= 1'b0;
      idx         <= '0;
      sh          <= '0;
      frame       <= '0;
      phy_addr    <= '0;
      reg_addr    <= '0;
      data        <= '0;
      is_read     <= 1'b0;
      frame_valid <= 1'b0;
      err_op      <= 1'b0;
      err_ta      <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      pre         <= pre_n;
      rd          <= rd_n;
      frame_valid <= done;
      err_op      <= bad_op;
      err_ta      <= bad_ta;
      if (stb) begin
        sh  <= word[30:0];
        idx <= (state == S_PRE) ? 5'd1 : idx + 5'd1;
      end
      if (done) begin
        frame       <= word;
        phy_addr    <= word[PHY_MSB -: 5];
        reg_addr    <= word[REG_MSB -: 5];
        data        <= word[DATA_MSB -: 16];
        is_read     <= rd;
        frame_count <= frame_count + 8'd1;
      end
    end
endmodule
